mips_mem_responder: RTL and testbench

//  Word-addressed data-memory responder: the target side of the processor's load/store memory port.

---
 rtl/mips_mem_responder.sv | 186 ++++++++++++++++++
 tb/tb_mips_mem_responder.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mem_responder.sv
// Word-addressed data-memory responder with programmable wait states.
// Optional MEM_STATS_EN adds saturating read/write/error counters.
module mips_mem_responder #(
  parameter int DEPTH       = 1024,
  parameter int AW          = $clog2(DEPTH),
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk1,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
`ifdef MEM_STATS_EN
  ,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count,
  output logic [15:0] err_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ready_q, ready_d;
  logic        valid_q, valid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic          acc;
  logic          acc_we;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic          in_range;
  logic          ram_we;
  logic [AW-1:0] ram_idx;

  logic [31:0] ram [DEPTH];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    acc       = 1'b0;
    acc_we    = we_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    in_range  = 1'b0;
    ram_we    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid && ready_q) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          // Zero wait states: access straight from the request bus.
          if (WAIT_CYCLES == 0) begin
            acc       = 1'b1;
            acc_we    = req_we;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            state_d   = S_RESP;
          end else begin
            cnt_d   = 4'(WAIT_CYCLES - 1);
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          acc     = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (acc) begin
      in_range = acc_addr < 32'(DEPTH);
      err_d    = !in_range;
      ram_we   = in_range && acc_we && rst_n;
      rdata_d  = (in_range && !acc_we) ?
                 ram[acc_addr[AW-1:0]] : '0;
    end
    ram_idx = acc_addr[AW-1:0];
    ready_d = (state_d == S_IDLE);
    valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk1) begin
    if (ram_we) ram[ram_idx] <= acc_wdata;
  end

  assign req_ready = ready_q;
  assign rsp_valid = valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

`ifdef MEM_STATS_EN
  logic [15:0] rd_q, rd_d;
  logic [15:0] wr_q, wr_d;
  logic [15:0] ec_q, ec_d;

  always_comb begin
    rd_d = rd_q;
    wr_d = wr_q;
    ec_d = ec_q;
    if (state_q == S_RESP && rsp_ready) begin
      if (err_q) begin
        if (ec_q != 16'hFFFF) ec_d = ec_q + 16'd1;
      end else if (we_q) begin
        if (wr_q != 16'hFFFF) wr_d = wr_q + 16'd1;
      end else begin
        if (rd_q != 16'hFFFF) rd_d = rd_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      rd_q <= '0;
      wr_q <= '0;
      ec_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      ec_q <= ec_d;
    end
  end

  assign rd_count  = rd_q;
  assign wr_count  = wr_q;
  assign err_count = ec_q;
`endif

endmodule

// File: tb/tb_mips_mem_responder.sv
// Directed bench for mips_mem_responder (WAIT_CYCLES=2 and 0 instances).
module tb_mips_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  logic        z_req_valid = 1'b0, z_req_we = 1'b0, z_rsp_ready = 1'b0;
  logic [31:0] z_req_addr = '0, z_req_wdata = '0;
  logic        z_req_ready, z_rsp_valid, z_rsp_err;
  logic [31:0] z_rsp_rdata;

`ifdef MEM_STATS_EN
  logic [15:0] rd_count, wr_count, err_count;
  logic [15:0] z_rd_count, z_wr_count, z_err_count;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mips_mem_responder #(.DEPTH(1024), .WAIT_CYCLES(2)) dut (
    .clk1(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
`ifdef MEM_STATS_EN
    , .rd_count(rd_count), .wr_count(wr_count), .err_count(err_count)
`endif
  );

  mips_mem_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) dut0 (
    .clk1(clk), .rst_n(rst_n),
    .req_valid(z_req_valid), .req_ready(z_req_ready),
    .req_we(z_req_we), .req_addr(z_req_addr), .req_wdata(z_req_wdata),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
    .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
`ifdef MEM_STATS_EN
    , .rd_count(z_rd_count), .wr_count(z_wr_count), .err_count(z_err_count)
`endif
  );

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 1'b0;
    z_req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One full transaction; lat = cycles from accept cycle to first rsp_valid.
  task automatic do_req(input bit sel, input logic we,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err,
                        output int lat);
    int n;
    @(negedge clk);
    if (sel) begin
      z_req_valid = 1'b1; z_req_we = we; z_req_addr = addr;
      z_req_wdata = wdata; z_rsp_ready = 1'b1;
    end else begin
      req_valid = 1'b1; req_we = we; req_addr = addr;
      req_wdata = wdata; rsp_ready = 1'b1;
    end
    n = 0;
    while (!(sel ? z_req_ready : req_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    if (sel) z_req_valid = 1'b0;
    else req_valid = 1'b0;
    lat = 1;
    while (!(sel ? z_rsp_valid : rsp_valid) && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    rdata = sel ? z_rsp_rdata : rsp_rdata;
    err   = sel ? z_rsp_err : rsp_err;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_req_ready got=%b exp=0", req_ready);
    end
    checks++;
    if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
      failures++;
      $display("FAIL rst_rsp got v=%b e=%b d=%h exp 0/0/0",
               rsp_valid, rsp_err, rsp_rdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_release_ready got=%b exp=1", req_ready);
    end
  endtask

  task automatic test_write_read();
    logic [31:0] d; logic e; int lat;
    do_req(1'b0, 1'b1, 32'd5, 32'hDEAD_BEEF, d, e, lat);
    checks++;
    if (lat !== 3 || e !== 1'b0 || d !== 32'h0) begin
      failures++;
      $display("FAIL wr5 got lat=%0d err=%b d=%h exp 3/0/0", lat, e, d);
    end
    do_req(1'b0, 1'b0, 32'd5, 32'h0, d, e, lat);
    checks++;
    if (lat !== 3 || e !== 1'b0 || d !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL rd5 got lat=%0d err=%b d=%h exp 3/0/deadbeef", lat, e, d);
    end
  endtask

  task automatic test_range();
    logic [31:0] d; logic e; int lat;
    do_req(1'b0, 1'b1, 32'd0, 32'h0000_1111, d, e, lat);
    do_req(1'b0, 1'b1, 32'd1023, 32'hCAFE_0123, d, e, lat);
    checks++;
    if (e !== 1'b0) begin
      failures++;
      $display("FAIL wr1023_err got=%b exp=0", e);
    end
    do_req(1'b0, 1'b0, 32'd1024, 32'h0, d, e, lat);
    checks++;
    if (e !== 1'b1 || d !== 32'h0) begin
      failures++;
      $display("FAIL rd1024 got err=%b d=%h exp 1/0", e, d);
    end
    do_req(1'b0, 1'b1, 32'd1024, 32'h0BAD_0001, d, e, lat);
    checks++;
    if (e !== 1'b1 || d !== 32'h0) begin
      failures++;
      $display("FAIL wr1024 got err=%b d=%h exp 1/0", e, d);
    end
    do_req(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0BAD_0002, d, e, lat);
    checks++;
    if (e !== 1'b1) begin
      failures++;
      $display("FAIL wrffff got err=%b exp 1", e);
    end
    do_req(1'b0, 1'b0, 32'd0, 32'h0, d, e, lat);
    checks++;
    if (e !== 1'b0 || d !== 32'h0000_1111) begin
      failures++;
      $display("FAIL rd0_alias got err=%b d=%h exp 0/00001111", e, d);
    end
  endtask

  task automatic test_hold();
    logic [31:0] d; logic e; int lat; int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'd1023;
    rsp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFE_0123 ||
          req_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold%0d got v=%b d=%h rdy=%b exp 1/cafe0123/0",
                 i, rsp_valid, rsp_rdata, req_ready);
      end
      req_valid = (i % 2 == 0);
      req_we = 1'b1; req_addr = 32'd0; req_wdata = 32'h0BAD_0003;
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL hold_release got v=%b d=%h rdy=%b exp 0/0/1",
               rsp_valid, rsp_rdata, req_ready);
    end
    do_req(1'b0, 1'b0, 32'd0, 32'h0, d, e, lat);
    checks++;
    if (d !== 32'h0000_1111) begin
      failures++;
      $display("FAIL hold_ignored got d=%h exp 00001111", d);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic e; int lat; int n;
    @(negedge clk);
    z_req_valid = 1'b1; z_req_we = 1'b1;
    z_req_addr = 32'd3; z_req_wdata = 32'h3333_0003;
    z_rsp_ready = 1'b1;
    n = 0;
    while (!z_req_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    checks++;
    if (z_rsp_valid !== 1'b1 || z_rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL b2b_rsp1 got v=%b e=%b exp 1/0", z_rsp_valid, z_rsp_err);
    end
    z_req_addr = 32'd4; z_req_wdata = 32'h4444_0004;
    n = 1;
    while (!z_req_ready && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (n < 2) begin
      failures++;
      $display("FAIL b2b_spacing got=%0d exp>=2", n);
    end
    @(negedge clk);
    z_req_valid = 1'b0;
    checks++;
    if (z_rsp_valid !== 1'b1 || z_rsp_rdata !== 32'h0) begin
      failures++;
      $display("FAIL b2b_rsp2 got v=%b d=%h exp 1/0", z_rsp_valid, z_rsp_rdata);
    end
    @(negedge clk);
    do_req(1'b1, 1'b0, 32'd3, 32'h0, d, e, lat);
    checks++;
    if (lat !== 1 || d !== 32'h3333_0003) begin
      failures++;
      $display("FAIL b2b_rd3 got lat=%0d d=%h exp 1/33330003", lat, d);
    end
    do_req(1'b1, 1'b0, 32'd4, 32'h0, d, e, lat);
    checks++;
    if (d !== 32'h4444_0004) begin
      failures++;
      $display("FAIL b2b_rd4 got d=%h exp 44440004", d);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic e; int lat; int n;
    do_req(1'b0, 1'b1, 32'd7, 32'h0000_AAAA, d, e, lat);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1;
    req_addr = 32'd7; req_wdata = 32'h0000_1234;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 ||
        rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL rst_wait got rdy=%b v=%b d=%h e=%b exp all 0",
               req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    rst_n = 1'b1;
    @(negedge clk);
    do_req(1'b0, 1'b0, 32'd7, 32'h0, d, e, lat);
    checks++;
    if (d !== 32'h0000_AAAA) begin
      failures++;
      $display("FAIL rst_wait_ram got d=%h exp 0000aaaa", d);
    end
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'd7;
    rsp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0) begin
      failures++;
      $display("FAIL rst_resp got v=%b d=%h exp 0/0", rsp_valid, rsp_rdata);
    end
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
  endtask

`ifdef MEM_STATS_EN
  task automatic test_stats();
    logic [31:0] d; logic e; int lat;
    apply_reset();
    do_req(1'b0, 1'b0, 32'd5, 32'h0, d, e, lat);
    do_req(1'b0, 1'b1, 32'd5, 32'hDEAD_BEEF, d, e, lat);
    do_req(1'b0, 1'b0, 32'd0, 32'h0, d, e, lat);
    do_req(1'b0, 1'b0, 32'd2000, 32'h0, d, e, lat);
    do_req(1'b0, 1'b1, 32'd0, 32'h0000_1111, d, e, lat);
    do_req(1'b0, 1'b0, 32'd1023, 32'h0, d, e, lat);
    checks++;
    if (rd_count !== 16'd3 || wr_count !== 16'd2 || err_count !== 16'd1) begin
      failures++;
      $display("FAIL stats got rd=%0d wr=%0d err=%0d exp 3/2/1",
               rd_count, wr_count, err_count);
    end
    apply_reset();
    checks++;
    if (rd_count !== 16'd0 || wr_count !== 16'd0 || err_count !== 16'd0) begin
      failures++;
      $display("FAIL stats_rst got rd=%0d wr=%0d err=%0d exp 0/0/0",
               rd_count, wr_count, err_count);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_write_read();
    test_range();
    test_hold();
    test_back_to_back();
    test_reset_mid();
`ifdef MEM_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
